stall_mem_responder: RTL and testbench

STALL_MEM_RESPONDER -- requirements
Module: stall_mem_responder

---
 rtl/stall_mem_responder.sv | 99 +++++++++
 tb/tb_stall_mem_responder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_mem_responder.sv
// Stalling single-port word memory responder: accepts one read or write at a time,
// holds the initiator for LATENCY cycles and pulses Done when the access completes.
module stall_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Stall,
  output logic        Done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] CntLoad = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic                rd_q, rd_d;
  logic [15:0]         mem_q [2**ADDR_W];

  logic can_accept;
  logic accept;
  logic unused_addr;

  // Upper address bits wrap silently; the reduction keeps lint quiet about them.
  assign unused_addr = ^Addr;

  assign can_accept = (state_q != StBusy) & ~rst;
  assign accept     = can_accept & (Rd ^ Wr) & ~Addr[0];
  assign err        = can_accept & ((Rd & Wr) | ((Rd | Wr) & Addr[0]));
  assign Stall      = (state_q == StBusy) | accept;
  assign Done       = (state_q == StDone);
  assign DataOut    = (Done && rd_q) ? mem_q[addr_q] : 16'h0000;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rd_d    = rd_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          addr_d = Addr[ADDR_W:1];
          data_d = DataIn;
          rd_d   = Rd;
          if (LATENCY > 1) begin
            cnt_d   = CntLoad;
            state_d = StBusy;
          end else begin
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
    end
  end

  // Writes commit on the edge that ends DONE; reset forces IDLE first, aborting them.
  always_ff @(posedge clk) begin
    if (state_q == StDone && !rd_q) begin
      mem_q[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Directed bench: LATENCY=4 instance for the main scenarios, LATENCY=1 instance for the
// single-cycle path.
module tb_stall_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd, wr;
  logic [15:0] addr, din, dout;
  logic        stall, done, err;
  logic        rd1, wr1;
  logic [15:0] addr1, din1, dout1;
  logic        stall1, done1, err1;

  int tests;
  int fails;

  stall_mem_responder #(.ADDR_W(8), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(dout), .Stall(stall), .Done(done), .err(err)
  );

  stall_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .Rd(rd1), .Wr(wr1), .Addr(addr1), .DataIn(din1),
    .DataOut(dout1), .Stall(stall1), .Done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d);
    rd = r; wr = w; addr = a; din = d;
  endtask

  task automatic write_txn(input logic [15:0] a, input logic [15:0] d);
    cyc(); set_in(1'b0, 1'b1, a, d);
    for (int i = 0; i < 4; i++) begin
      cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  task automatic read_txn(input logic [15:0] a, output logic [15:0] data,
                          output logic seen);
    cyc(); set_in(1'b1, 1'b0, a, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    cyc();
    @(negedge clk);
    data = dout;
    seen = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 16'h0011, 16'hFFFF);
    @(negedge clk);
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (dout !== 16'h0000) begin fails++; $display("FAIL reset_dout got %h want 0000", dout); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
    cyc();
    set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    tests++; if ({stall, done, err} !== 3'b000) begin
      fails++; $display("FAIL post_reset_idle got %b want 000", {stall, done, err});
    end
  endtask

  task automatic test_write_read();
    cyc(); set_in(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    @(negedge clk);
    tests++; if ({stall, done} !== 2'b10) begin
      fails++; $display("FAIL wr_accept got %b want 10", {stall, done});
    end
    // Garbage that would be an error in IDLE must be ignored while BUSY.
    for (int i = 1; i <= 3; i++) begin
      cyc(); set_in(1'b1, 1'b0, 16'h0031, 16'hFFFF);
      @(negedge clk);
      tests++; if ({stall, done, err} !== 3'b100) begin
        fails++; $display("FAIL wr_busy%0d got %b want 100", i, {stall, done, err});
      end
    end
    cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    tests++; if ({stall, done} !== 2'b01 || dout !== 16'h0000) begin
      fails++; $display("FAIL wr_done got %b/%h want 01/0000", {stall, done}, dout);
    end
    cyc(); set_in(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    tests++; if ({stall, done} !== 2'b10) begin
      fails++; $display("FAIL rd_accept got %b want 10", {stall, done});
    end
    for (int i = 6; i <= 8; i++) begin
      cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      tests++; if ({stall, done} !== 2'b10) begin
        fails++; $display("FAIL rd_busy_t%0d got %b want 10", i, {stall, done});
      end
    end
    cyc();
    @(negedge clk);
    tests++; if ({stall, done} !== 2'b01 || dout !== 16'hBEEF) begin
      fails++; $display("FAIL rd_done got %b/%h want 01/beef", {stall, done}, dout);
    end
    cyc();
    @(negedge clk);
    tests++; if (done !== 1'b0 || dout !== 16'h0000) begin
      fails++; $display("FAIL rd_after got %b/%h want 0/0000", done, dout);
    end
  endtask

  task automatic test_back_to_back();
    cyc(); set_in(1'b0, 1'b1, 16'h0010, 16'hC0DE);
    for (int i = 0; i < 3; i++) begin
      cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    end
    cyc(); set_in(1'b1, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    tests++; if ({stall, done} !== 2'b11 || dout !== 16'h0000) begin
      fails++; $display("FAIL b2b_overlap got %b/%h want 11/0000", {stall, done}, dout);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      tests++; if ({stall, done} !== 2'b10) begin
        fails++; $display("FAIL b2b_busy%0d got %b want 10", i, {stall, done});
      end
    end
    cyc();
    @(negedge clk);
    tests++; if ({stall, done} !== 2'b01 || dout !== 16'hC0DE) begin
      fails++; $display("FAIL b2b_read got %b/%h want 01/c0de", {stall, done}, dout);
    end
  endtask

  task automatic test_errors();
    logic [15:0] data;
    logic        seen;
    cyc(); set_in(1'b1, 1'b1, 16'h0010, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if ({err, stall, done} !== 3'b100) begin
        fails++; $display("FAIL err_rdwr%0d got %b want 100", i, {err, stall, done});
      end
      cyc();
    end
    set_in(1'b0, 1'b1, 16'h0011, 16'h1234);
    @(negedge clk);
    tests++; if ({err, stall, done} !== 3'b100) begin
      fails++; $display("FAIL err_odd_wr got %b want 100", {err, stall, done});
    end
    cyc(); set_in(1'b1, 1'b0, 16'h0013, 16'h0000);
    @(negedge clk);
    tests++; if ({err, stall} !== 2'b10) begin
      fails++; $display("FAIL err_odd_rd got %b want 10", {err, stall});
    end
    cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    tests++; if ({err, stall, done} !== 3'b000) begin
      fails++; $display("FAIL err_clear got %b want 000", {err, stall, done});
    end
    read_txn(16'h0010, data, seen);
    tests++; if (seen !== 1'b1 || data !== 16'hC0DE) begin
      fails++; $display("FAIL err_mem_kept got %b/%h want 1/c0de", seen, data);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] data;
    logic        seen;
    logic        bad;
    write_txn(16'h0020, 16'h1111);
    cyc(); set_in(1'b0, 1'b1, 16'h0020, 16'h5555);
    @(negedge clk);
    tests++; if (stall !== 1'b1) begin
      fails++; $display("FAIL rstmid_accept got %b want 1", stall);
    end
    cyc(); set_in(1'b0, 1'b0, 16'h0000, 16'h0000);
    cyc();
    #2;
    rst = 1'b1;
    #1;
    tests++; if ({stall, done} !== 2'b00) begin
      fails++; $display("FAIL rstmid_async got %b want 00", {stall, done});
    end
    cyc();
    #2;
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || stall !== 1'b0) bad = 1'b1;
      cyc();
    end
    tests++; if (bad !== 1'b0) begin
      fails++; $display("FAIL rstmid_no_done got %b want 0", bad);
    end
    read_txn(16'h0020, data, seen);
    tests++; if (seen !== 1'b1 || data !== 16'h1111) begin
      fails++; $display("FAIL rstmid_mem got %b/%h want 1/1111", seen, data);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] data;
    logic        seen;
    write_txn(16'h0202, 16'hA5A5);
    read_txn(16'h0002, data, seen);
    tests++; if (seen !== 1'b1 || data !== 16'hA5A5) begin
      fails++; $display("FAIL wrap got %b/%h want 1/a5a5", seen, data);
    end
  endtask

  task automatic test_latency1();
    cyc(); rd1 = 1'b0; wr1 = 1'b1; addr1 = 16'h0004; din1 = 16'h7E7E;
    @(negedge clk);
    tests++; if ({stall1, done1} !== 2'b10) begin
      fails++; $display("FAIL l1_wr got %b want 10", {stall1, done1});
    end
    cyc(); rd1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0004; din1 = 16'h0000;
    @(negedge clk);
    tests++; if ({stall1, done1} !== 2'b11 || dout1 !== 16'h0000) begin
      fails++; $display("FAIL l1_b2b got %b/%h want 11/0000", {stall1, done1}, dout1);
    end
    cyc(); rd1 = 1'b0;
    @(negedge clk);
    tests++; if ({stall1, done1} !== 2'b01 || dout1 !== 16'h7E7E) begin
      fails++; $display("FAIL l1_rd got %b/%h want 01/7e7e", {stall1, done1}, dout1);
    end
    cyc();
    @(negedge clk);
    tests++; if ({stall1, done1} !== 2'b00) begin
      fails++; $display("FAIL l1_idle got %b want 00", {stall1, done1});
    end
    cyc(); rd1 = 1'b1; addr1 = 16'h0004;
    @(negedge clk);
    tests++; if ({stall1, done1} !== 2'b10) begin
      fails++; $display("FAIL l1_rd2_accept got %b want 10", {stall1, done1});
    end
    cyc(); rd1 = 1'b0;
    @(negedge clk);
    tests++; if ({stall1, done1} !== 2'b01 || dout1 !== 16'h7E7E) begin
      fails++; $display("FAIL l1_rd2_done got %b/%h want 01/7e7e", {stall1, done1}, dout1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0000; din1 = 16'h0000;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_reset_mid_write();
    test_wrap();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
